// File: rtl/servo_pulse_capture_pkg.sv
// rtl/servo_pulse_capture_pkg.sv - shared servo timing constants, capture FSM states and helpers
package servo_pulse_capture_pkg;

    // 25 MHz system clock; shared with the servo PWM generator
    localparam int TICKS_PER_US = 25;
    localparam int US_W         = 32;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_LOST = 2'd3
    } capture_state_t;

    // Saturating increment: counts stop at lim so they can never wrap
    function automatic logic [US_W-1:0] sat_inc(
        input logic [US_W-1:0] value,
        input logic            inc,
        input logic [US_W-1:0] lim
    );
        if (inc && (value < lim)) begin
            return value + 1'b1;
        end
        return value;
    endfunction

    // Inclusive window test used for the in_range flag
    function automatic logic in_window(
        input logic [US_W-1:0] value,
        input logic [US_W-1:0] lo,
        input logic [US_W-1:0] hi
    );
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/servo_pulse_capture_sync_edge_detect.sv
// rtl/servo_pulse_capture_sync_edge_detect.sv - 2-flop synchronizer plus registered rise/fall detector
module sync_edge_detect (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic       sync_q1;
    logic       sync_q2;
    logic       edge_q;
    logic [1:0] fill;
    logic       primed;

    // Edges are only trusted once every stage holds a real sample, so a line
    // already high at reset release is not mistaken for a rising edge.
    assign primed = (fill == 2'd3);

    // Synchronizer, history register and single-cycle edge strobes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            edge_q  <= 1'b0;
            fill    <= 2'd0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            edge_q  <= sync_q2;
            if (!primed) begin
                fill <= fill + 2'd1;
            end
            rise <= primed &  sync_q2 & ~edge_q;
            fall <= primed & ~sync_q2 &  edge_q;
        end
    end

endmodule

// File: rtl/servo_pulse_capture.sv
// rtl/servo_pulse_capture.sv - servo PWM high-time and period capture with range and timeout flags
module servo_pulse_capture #(
    parameter int TICKS_PER_US = servo_pulse_capture_pkg::TICKS_PER_US,
    parameter int MIN_US       = 500,
    parameter int MAX_US       = 2500,
    parameter int TIMEOUT_US   = 25000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PMOD,
    output logic [31:0] pulse_us,
    output logic [31:0] period_us,
    output logic        valid,
    output logic        in_range,
    output logic        timeout
);

    import servo_pulse_capture_pkg::*;

    localparam int              PW         = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_US - 1);
    localparam logic [US_W-1:0] LIM        = US_W'(TIMEOUT_US);
    localparam logic [US_W-1:0] LO         = US_W'(MIN_US);
    localparam logic [US_W-1:0] HI         = US_W'(MAX_US);

    capture_state_t  state;
    capture_state_t  state_next;

    logic            rise;
    logic            fall;

    logic [PW-1:0]   presc;
    logic            tick;
    logic [US_W-1:0] phase_cnt;
    logic [US_W-1:0] period_cnt;
    logic [US_W-1:0] phase_next;
    logic [US_W-1:0] period_next;
    logic [US_W-1:0] high_lat;
    logic            phase_expired;

    logic            clr_all;
    logic            clr_phase;
    logic            latch_high;
    logic            emit;
    logic            set_to;
    logic            clr_to;

    sync_edge_detect u_sync (
        .CLK  (CLK),
        .RST  (RST),
        .din  (PMOD),
        .rise (rise),
        .fall (fall)
    );

    // Values the counters take at the coming edge; latching these (rather than
    // the current count) makes the measured width floor(ticks / TICKS_PER_US).
    assign tick          = (presc == PRESC_LAST);
    assign phase_next    = sat_inc(phase_cnt, tick, LIM);
    assign period_next   = sat_inc(period_cnt, tick, LIM);
    assign phase_expired = (phase_next >= LIM);

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_ARM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes; an edge always takes priority over a timeout
    always_comb begin
        state_next = state;
        clr_all    = 1'b0;
        clr_phase  = 1'b0;
        latch_high = 1'b0;
        emit       = 1'b0;
        set_to     = 1'b0;
        clr_to     = 1'b0;
        unique case (state)
            ST_ARM: begin
                if (rise) begin
                    state_next = ST_HIGH;
                    clr_all    = 1'b1;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_next = ST_LOW;
                    latch_high = 1'b1;
                    clr_phase  = 1'b1;
                end else if (phase_expired) begin
                    state_next = ST_LOST;
                    set_to     = 1'b1;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_next = ST_HIGH;
                    clr_all    = 1'b1;
                    emit       = 1'b1;
                end else if (phase_expired) begin
                    state_next = ST_LOST;
                    set_to     = 1'b1;
                end
            end
            ST_LOST: begin
                if (rise) begin
                    state_next = ST_HIGH;
                    clr_all    = 1'b1;
                    clr_to     = 1'b1;
                end
            end
            default: begin
                state_next = ST_ARM;
            end
        endcase
    end

    // Tick prescaler and µs counters; phase restarts on each edge, period on each rise
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc      <= '0;
            phase_cnt  <= '0;
            period_cnt <= '0;
        end else begin
            if (clr_all || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
            if (clr_all || clr_phase) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_next;
            end
            if (clr_all) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_next;
            end
        end
    end

    // High time is held internally until the frame closes so outputs move only with valid
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            high_lat <= '0;
        end else if (latch_high) begin
            high_lat <= phase_next;
        end
    end

    // Published results, the valid strobe and the range flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pulse_us  <= '0;
            period_us <= '0;
            in_range  <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= emit;
            if (emit) begin
                pulse_us  <= high_lat;
                period_us <= period_next;
                in_range  <= in_window(high_lat, LO, HI);
            end
        end
    end

    // Signal-lost level flag, cleared only by the rise that restarts capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timeout <= 1'b0;
        end else if (set_to) begin
            timeout <= 1'b1;
        end else if (clr_to) begin
            timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_servo_pulse_capture.sv
// tb/tb_servo_pulse_capture.sv - scoreboard bench for servo_pulse_capture
module tb_servo_pulse_capture;

    localparam int T = 2;

    logic        CLK;
    logic        RST;
    logic        PMOD;
    logic [31:0] pulse_us;
    logic [31:0] period_us;
    logic        valid;
    logic        in_range;
    logic        timeout;

    typedef struct {
        int    pulse;
        int    period;
        bit    rng;
        int    tol;
        longint cyc;
    } exp_t;

    exp_t   sbq[$];
    exp_t   pend_e;
    bit     pend;
    longint cyc;
    longint chg_cyc;
    int     n_cmp;
    int     n_err;
    logic [31:0] last_pulse;
    logic [31:0] last_period;
    logic        last_rng;

    servo_pulse_capture #(
        .TICKS_PER_US (T),
        .MIN_US       (500),
        .MAX_US       (2500),
        .TIMEOUT_US   (5000)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PMOD      (PMOD),
        .pulse_us  (pulse_us),
        .period_us (period_us),
        .valid     (valid),
        .in_range  (in_range),
        .timeout   (timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #20 CLK = ~CLK;
    end

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input bit ok, input longint act, input longint req);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: pop and compare on every valid; outputs must hold otherwise
    always @(negedge CLK) begin
        if (RST) begin
            last_pulse  <= pulse_us;
            last_period <= period_us;
            last_rng    <= in_range;
        end else begin
            if (valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 1'b0, cyc, -1);
                end else begin
                    exp_t e;
                    int dp;
                    int dq;
                    e  = sbq.pop_front();
                    dp = int'(pulse_us) - e.pulse;
                    dq = int'(period_us) - e.period;
                    chk("pulse_us", (dp <= e.tol) && (dp >= -e.tol), pulse_us, e.pulse);
                    chk("period_us", (dq <= e.tol) && (dq >= -e.tol), period_us, e.period);
                    chk("in_range", in_range == e.rng, in_range, e.rng);
                    chk("timeout_at_valid", timeout == 1'b0, timeout, 0);
                    chk("valid_latency_cycle", cyc == e.cyc, cyc, e.cyc);
                end
            end else begin
                chk("outputs_hold",
                    (pulse_us == last_pulse) && (period_us == last_period) && (in_range == last_rng),
                    pulse_us, last_pulse);
            end
            last_pulse  <= pulse_us;
            last_period <= period_us;
            last_rng    <= in_range;
        end
    end

    task automatic set_pmod(input logic v, input bit rnd);
        @(posedge CLK);
        if (rnd) #($urandom_range(1, 39));
        else #3;
        PMOD = v;
        chg_cyc = cyc;
    endtask

    task automatic hold_cyc(input int n);
        repeat (n - 1) @(posedge CLK);
    endtask

    task automatic hold(input int us);
        hold_cyc(us * T);
    endtask

    task automatic rise(input bit rnd);
        set_pmod(1'b1, rnd);
        if (pend) begin
            pend_e.cyc = chg_cyc + 4;
            sbq.push_back(pend_e);
            pend = 1'b0;
        end
    endtask

    // One frame: rise, p µs high, l µs low; its valid comes with the next rise
    task automatic frame(input int p, input int l, input bit rng, input bit rnd, input bit expect_v);
        rise(rnd);
        hold(p);
        set_pmod(1'b0, rnd);
        hold(l);
        if (expect_v) begin
            pend_e.pulse  = p;
            pend_e.period = p + l;
            pend_e.rng    = rng;
            pend_e.tol    = rnd ? 1 : 0;
            pend   = 1'b1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pulse"},   pulse_us == 0,  pulse_us, 0);
        chk({tag, "_period"},  period_us == 0, period_us, 0);
        chk({tag, "_valid"},   valid == 0,     valid, 0);
        chk({tag, "_inrange"}, in_range == 0,  in_range, 0);
        chk({tag, "_timeout"}, timeout == 0,   timeout, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        pend  = 1'b0;
        PMOD  = 1'b1;
        RST   = 1'b1;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check_zero("reset");
        @(posedge CLK);
        #3 RST = 1'b0;

        // Line already high at release: ignored until it falls and rises
        hold(300);
        set_pmod(1'b0, 1'b0);
        hold(400);
        frame(1500, 400, 1'b1, 1'b0, 1'b1);
        frame(1500, 400, 1'b1, 1'b0, 1'b1);
        frame(2600, 400, 1'b0, 1'b0, 1'b1);
        frame(400,  400, 1'b0, 1'b0, 1'b1);
        frame(2500, 400, 1'b1, 1'b0, 1'b1);
        frame(500,  400, 1'b1, 1'b0, 1'b1);

        // Sub-microsecond pulse: one CLK high, 800 CLK low -> 0 µs / 400 µs
        rise(1'b0);
        hold_cyc(1);
        set_pmod(1'b0, 1'b0);
        hold_cyc(800);
        pend_e.pulse  = 0;
        pend_e.period = 400;
        pend_e.rng    = 1'b0;
        pend_e.tol    = 0;
        pend = 1'b1;

        // Good frame, then a low phase beyond the timeout
        frame(1500, 400, 1'b1, 1'b0, 1'b1);
        rise(1'b0);
        hold(1500);
        set_pmod(1'b0, 1'b0);
        hold(4900);
        @(negedge CLK);
        chk("timeout_before_limit", timeout == 1'b0, timeout, 0);
        hold(200);
        @(negedge CLK);
        chk("timeout_after_limit", timeout == 1'b1, timeout, 1);
        chk("timeout_pulse_hold", pulse_us == 1500, pulse_us, 1500);
        chk("timeout_period_hold", period_us == 1900, period_us, 1900);
        chk("timeout_inrange_hold", in_range == 1'b1, in_range, 1);
        hold(1000);
        frame(1500, 400, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        chk("timeout_cleared", timeout == 1'b0, timeout, 0);

        // Reset 700 µs into a pulse
        frame(1500, 400, 1'b1, 1'b0, 1'b1);
        rise(1'b0);
        hold(700);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check_zero("midpulse_reset");
        repeat (5) @(posedge CLK);
        #3 RST = 1'b0;
        hold(800);
        set_pmod(1'b0, 1'b0);
        hold(400);
        frame(1500, 400, 1'b1, 1'b0, 1'b1);
        frame(1000, 400, 1'b1, 1'b0, 1'b1);

        // Random phase relative to CLK
        frame(1500, 400, 1'b1, 1'b1, 1'b1);
        frame(1800, 400, 1'b1, 1'b1, 1'b1);
        frame(1500, 400, 1'b1, 1'b1, 1'b1);
        rise(1'b1);
        hold(100);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        chk("scoreboard_drained", sbq.size() == 0, sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
